// File: rtl/fifo_27_reader_if.sv
// Read-side bundle for fifo_27_reader: FIFO read port plus the downstream valid/ready stream.
interface fifo_27_reader_if #(
  parameter int unsigned WIDTH = 27
);
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_empty;
  logic             fifo_rst_busy;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    input  fifo_dout, fifo_empty, fifo_rst_busy, out_ready,
    output fifo_rd_en, out_data, out_valid
  );

  modport slave (
    output fifo_dout, fifo_empty, fifo_rst_busy, out_ready,
    input  fifo_rd_en, out_data, out_valid
  );
endinterface

// File: rtl/fifo_27_reader.sv
// Drains a standard-mode FIFO: issues reads, captures dout after the read latency into a
// small circular skid buffer, and presents it as a full-throughput valid/ready stream.
module fifo_27_reader #(
  parameter int unsigned WIDTH        = 27,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             read_clk,
  input  logic             rst_n,
  fifo_27_reader_if.master bus,
  output logic [CNT_W-1:0] words_out,
  output logic             overflow_err
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned INF_W = $clog2(READ_LATENCY + 1);
  localparam int unsigned SUM_W = $clog2(DEPTH + READ_LATENCY + 2);

  logic [WIDTH-1:0]        mem [DEPTH];
  logic [PTR_W-1:0]        head, tail, head_n, tail_n;
  logic [OCC_W-1:0]        occ, occ_n;
  logic [READ_LATENCY-1:0] issue_sr;
  logic                    run;
  logic [INF_W-1:0]        inflight;
  logic                    pop, capture, full, wr, rd_en_c;
  logic [WIDTH-1:0]        head_data_n;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Reads issued but not yet returned
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(READ_LATENCY); i++) begin
      inflight = inflight + INF_W'(issue_sr[i]);
    end
  end

  assign pop     = bus.out_valid && bus.out_ready;
  assign capture = issue_sr[READ_LATENCY-1];
  assign full    = (occ == OCC_W'(DEPTH));
  assign wr      = capture && (!full || pop);

  // Only issue when the word is guaranteed a slot on return; run blocks the first cycle out of reset
  assign rd_en_c = run && !bus.fifo_empty && !bus.fifo_rst_busy &&
                   ((SUM_W'(occ) + SUM_W'(inflight) + SUM_W'(1)) <= (SUM_W'(DEPTH) + SUM_W'(pop)));
  assign bus.fifo_rd_en = rd_en_c;

  always_comb begin
    head_n = pop ? wrap_inc(head) : head;
    tail_n = wr  ? wrap_inc(tail) : tail;
    occ_n  = occ;
    if (wr && !pop) begin
      occ_n = occ + OCC_W'(1);
    end else if (!wr && pop) begin
      occ_n = occ - OCC_W'(1);
    end
    // New head is the word being captured when everything older has just left
    head_data_n = (wr && (tail == head_n)) ? bus.fifo_dout : mem[head_n];
  end

  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      run           <= 1'b0;
      issue_sr      <= '0;
      head          <= '0;
      tail          <= '0;
      occ           <= '0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      words_out     <= '0;
      overflow_err  <= 1'b0;
    end else begin
      run           <= 1'b1;
      issue_sr      <= READ_LATENCY'({issue_sr, rd_en_c});
      head          <= head_n;
      tail          <= tail_n;
      occ           <= occ_n;
      bus.out_valid <= (occ_n != '0);
      if (occ_n != '0) begin
        bus.out_data <= head_data_n;
      end
      if (pop) begin
        words_out <= words_out + CNT_W'(1);
      end
      if (capture && full && !pop) begin
        overflow_err <= 1'b1;
      end
    end
  end

  // Buffer storage needs no reset: occ gates every read of it
  always_ff @(posedge read_clk) begin
    if (wr) begin
      mem[tail] <= bus.fifo_dout;
    end
  end
endmodule

// File: tb/tb_fifo_27_reader.sv
// Directed and random checks of fifo_27_reader at READ_LATENCY 1 (dut1) and 2 (dut2, 4-bit counter).
module tb_fifo_27_reader;
  localparam int unsigned W = 27;
  localparam int N_RAND = 10000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_27_reader_if #(.WIDTH(W)) bus1 ();
  fifo_27_reader_if #(.WIDTH(W)) bus2 ();
  logic [15:0] words1;
  logic        ovf1;
  logic [3:0]  words2;
  logic        ovf2;

  fifo_27_reader #(.WIDTH(W), .READ_LATENCY(1), .DEPTH(2), .CNT_W(16)) dut1 (
    .read_clk(clk), .rst_n(rst_n), .bus(bus1.master), .words_out(words1), .overflow_err(ovf1));
  fifo_27_reader #(.WIDTH(W), .READ_LATENCY(2), .DEPTH(3), .CNT_W(4)) dut2 (
    .read_clk(clk), .rst_n(rst_n), .bus(bus2.master), .words_out(words2), .overflow_err(ovf2));

  logic [W-1:0] q1[$], q2[$], exp1[$], exp2[$];
  logic         hold1, hold2;
  logic [W-1:0] stage2;
  int           n_checks = 0;
  int           n_fail   = 0;

  // FIFO models: hold forces the empty flag even when words are present
  assign bus1.fifo_empty = (q1.size() == 0) || hold1;
  assign bus2.fifo_empty = (q2.size() == 0) || hold2;

  always @(posedge clk) begin
    if (bus1.fifo_rd_en && q1.size() != 0) bus1.fifo_dout <= q1.pop_front();
    if (bus2.fifo_rd_en && q2.size() != 0) stage2 <= q2.pop_front();
    bus2.fifo_dout <= stage2;
  end

  task automatic do_reset(input logic r1, input logic r2);
    rst_n = 1'b0;
    q1.delete(); q2.delete(); exp1.delete(); exp2.delete();
    hold1 = 1'b0; hold2 = 1'b0;
    bus1.fifo_rst_busy = 1'b0; bus2.fifo_rst_busy = 1'b0;
    bus1.out_ready = r1; bus2.out_ready = r2;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    q1.push_back(W'(27'h1234567));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if (bus1.fifo_rd_en !== 1'b0 || bus1.out_valid !== 1'b0 || words1 !== 16'd0 ||
          bus1.out_data !== W'(0) || ovf1 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: rd_en=%b valid=%b words=%0d data=%h ovf=%b expected all zero",
                 bus1.fifo_rd_en, bus1.out_valid, words1, bus1.out_data, ovf1);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus1.fifo_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_first_cycle: rd_en=%b expected 0", bus1.fifo_rd_en);
    end
    @(negedge clk); #1;
    n_checks++;
    if (bus1.fifo_rd_en !== 1'b1) begin
      n_fail++; $display("FAIL reset_second_cycle: rd_en=%b expected 1", bus1.fifo_rd_en);
    end
  endtask

  task automatic test_streaming();
    int cyc_rd, cyc_val, npop;
    logic [W-1:0] e;
    do_reset(1'b1, 1'b0);
    for (int i = 1; i <= 16; i++) begin q1.push_back(W'(i)); exp1.push_back(W'(i)); end
    cyc_rd = -1; cyc_val = -1; npop = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (bus1.fifo_rd_en && cyc_rd < 0) cyc_rd = cyc;
      if (bus1.out_valid && cyc_val < 0) cyc_val = cyc;
      if (cyc_val >= 0 && npop < 16) begin
        n_checks++;
        if (bus1.out_valid !== 1'b1) begin
          n_fail++; $display("FAIL stream_gap: cycle %0d valid=%b expected 1", cyc, bus1.out_valid);
        end
      end
      if (bus1.out_valid && bus1.out_ready) begin
        e = (exp1.size() != 0) ? exp1.pop_front() : W'(0);
        n_checks++;
        if (bus1.out_data !== e) begin
          n_fail++; $display("FAIL stream_data: got %h expected %h", bus1.out_data, e);
        end
        npop++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (cyc_val - cyc_rd != 2) begin
      n_fail++; $display("FAIL stream_latency: got %0d expected 2", cyc_val - cyc_rd);
    end
    n_checks++;
    if (npop != 16 || words1 !== 16'd16) begin
      n_fail++; $display("FAIL stream_count: pops=%0d words=%0d expected 16", npop, words1);
    end
  endtask

  task automatic test_backpressure();
    int npop, npop_pre;
    logic [W-1:0] e, frozen;
    do_reset(1'b1, 1'b0);
    for (int i = 1; i <= 30; i++) begin q1.push_back(W'(i)); exp1.push_back(W'(i)); end
    npop = 0; npop_pre = 0; frozen = '0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      bus1.out_ready = !(cyc >= 8 && cyc < 18);
      #1;
      if (cyc == 8) begin frozen = bus1.out_data; npop_pre = npop; end
      if (cyc >= 8 && cyc < 18) begin
        n_checks++;
        if (bus1.out_valid !== 1'b1 || bus1.out_data !== frozen) begin
          n_fail++;
          $display("FAIL bp_frozen: cycle %0d valid=%b data=%h expected 1/%h", cyc, bus1.out_valid, bus1.out_data, frozen);
        end
      end
      if (cyc >= 10 && cyc < 18) begin
        n_checks++;
        if (bus1.fifo_rd_en !== 1'b0) begin
          n_fail++; $display("FAIL bp_rd_en: cycle %0d rd_en=%b expected 0", cyc, bus1.fifo_rd_en);
        end
      end
      if (cyc == 17) begin
        n_checks++;
        if (q1.size() != 30 - npop_pre - 2) begin
          n_fail++; $display("FAIL bp_buffered: fifo left %0d expected %0d", q1.size(), 30 - npop_pre - 2);
        end
      end
      if (bus1.out_valid && bus1.out_ready) begin
        e = (exp1.size() != 0) ? exp1.pop_front() : W'(0);
        n_checks++;
        if (bus1.out_data !== e) begin
          n_fail++; $display("FAIL bp_data: got %h expected %h", bus1.out_data, e);
        end
        npop++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (npop != 30 || words1 !== 16'd30 || ovf1 !== 1'b0) begin
      n_fail++; $display("FAIL bp_total: pops=%0d words=%0d ovf=%b expected 30/30/0", npop, words1, ovf1);
    end
  endtask

  task automatic test_random();
    int got1, got2, sent1, sent2;
    logic [W-1:0] v, e;
    do_reset(1'b0, 1'b0);
    got1 = 0; got2 = 0; sent1 = 0; sent2 = 0;
    for (int cyc = 0; cyc < 80000 && (got1 < N_RAND || got2 < N_RAND); cyc++) begin
      if (sent1 < N_RAND && q1.size() < 4 && $urandom_range(0, 3) != 0) begin
        v = W'($urandom); q1.push_back(v); exp1.push_back(v); sent1++;
      end
      if (sent2 < N_RAND && q2.size() < 4 && $urandom_range(0, 3) != 0) begin
        v = W'($urandom); q2.push_back(v); exp2.push_back(v); sent2++;
      end
      hold1 = ($urandom_range(0, 3) == 0);
      hold2 = ($urandom_range(0, 3) == 0);
      bus1.fifo_rst_busy = ($urandom_range(0, 9) == 0);
      bus2.fifo_rst_busy = ($urandom_range(0, 9) == 0);
      bus1.out_ready = 1'($urandom_range(0, 1));
      bus2.out_ready = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if (bus1.fifo_rd_en && (bus1.fifo_empty || bus1.fifo_rst_busy)) begin
        n_fail++; $display("FAIL rand_illegal_rd1: cycle %0d rd_en=1 expected 0", cyc);
      end
      n_checks++;
      if (bus2.fifo_rd_en && (bus2.fifo_empty || bus2.fifo_rst_busy)) begin
        n_fail++; $display("FAIL rand_illegal_rd2: cycle %0d rd_en=1 expected 0", cyc);
      end
      if (bus1.out_valid && bus1.out_ready) begin
        e = (exp1.size() != 0) ? exp1.pop_front() : W'(0);
        n_checks++;
        if (bus1.out_data !== e) begin
          n_fail++; $display("FAIL rand_data1: word %0d got %h expected %h", got1, bus1.out_data, e);
        end
        got1++;
      end
      if (bus2.out_valid && bus2.out_ready) begin
        e = (exp2.size() != 0) ? exp2.pop_front() : W'(0);
        n_checks++;
        if (bus2.out_data !== e) begin
          n_fail++; $display("FAIL rand_data2: word %0d got %h expected %h", got2, bus2.out_data, e);
        end
        got2++;
      end
      @(negedge clk);
    end
    hold1 = 1'b0; hold2 = 1'b0; bus1.fifo_rst_busy = 1'b0; bus2.fifo_rst_busy = 1'b0;
    n_checks++;
    if (got1 != N_RAND || got2 != N_RAND) begin
      n_fail++; $display("FAIL rand_complete: got %0d/%0d expected %0d", got1, got2, N_RAND);
    end
    n_checks++;
    if (ovf1 !== 1'b0 || ovf2 !== 1'b0 || words1 !== 16'(N_RAND) || words2 !== 4'(N_RAND)) begin
      n_fail++;
      $display("FAIL rand_status: ovf=%b/%b words=%0d/%0d expected 0/0 %0d/%0d",
               ovf1, ovf2, words1, words2, 16'(N_RAND), 4'(N_RAND));
    end
  endtask

  task automatic test_rst_busy();
    bit found;
    do_reset(1'b0, 1'b0);
    q1.push_back(W'(27'h5A5A5A5));
    q1.push_back(W'(27'h0000ABC));
    #1;
    n_checks++;
    if (bus1.fifo_rd_en !== 1'b1) begin
      n_fail++; $display("FAIL busy_first_issue: rd_en=%b expected 1", bus1.fifo_rd_en);
    end
    @(negedge clk);
    bus1.fifo_rst_busy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++;
      if (bus1.fifo_rd_en !== 1'b0) begin
        n_fail++; $display("FAIL busy_no_issue: cycle %0d rd_en=%b expected 0", c, bus1.fifo_rd_en);
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (bus1.out_valid !== 1'b1 || bus1.out_data !== W'(27'h5A5A5A5) || q1.size() != 1) begin
      n_fail++;
      $display("FAIL busy_inflight: valid=%b data=%h fifo_left=%0d expected 1/5a5a5a5/1",
               bus1.out_valid, bus1.out_data, q1.size());
    end
    bus1.out_ready = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (words1 !== 16'd1 || bus1.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL busy_pop: words=%0d valid=%b expected 1/0", words1, bus1.out_valid);
    end
    bus1.fifo_rst_busy = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk); #1;
      if (bus1.out_valid) found = 1'b1;
    end
    n_checks++;
    if (!found || bus1.out_data !== W'(27'h0000ABC)) begin
      n_fail++; $display("FAIL busy_resume: found=%b data=%h expected 1/0000abc", found, bus1.out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int cyc_rd, cyc_val, npop;
    logic [W-1:0] e;
    do_reset(1'b0, 1'b1);
    for (int i = 0; i < 17; i++) begin q2.push_back(W'(32'h100 + i)); exp2.push_back(W'(32'h100 + i)); end
    cyc_rd = -1; cyc_val = -1; npop = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      #1;
      if (bus2.fifo_rd_en && cyc_rd < 0) cyc_rd = cyc;
      if (bus2.out_valid && cyc_val < 0) cyc_val = cyc;
      if (bus2.out_valid && bus2.out_ready) begin
        e = (exp2.size() != 0) ? exp2.pop_front() : W'(0);
        n_checks++;
        if (bus2.out_data !== e) begin
          n_fail++; $display("FAIL wrap_data: got %h expected %h", bus2.out_data, e);
        end
        npop++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (cyc_val - cyc_rd != 3) begin
      n_fail++; $display("FAIL wrap_latency: got %0d expected 3", cyc_val - cyc_rd);
    end
    n_checks++;
    if (npop != 17 || words2 !== 4'd1) begin
      n_fail++; $display("FAIL wrap_count: pops=%0d words=%0d expected 17/1", npop, words2);
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) q1.push_back(W'(32'h200 + i));
    repeat (6) @(negedge clk);
    #1;
    n_checks++;
    if (bus1.out_valid !== 1'b1 || words1 !== 16'd4) begin
      n_fail++; $display("FAIL arst_pre: valid=%b words=%0d expected 1/4", bus1.out_valid, words1);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus1.out_valid !== 1'b0 || bus1.out_data !== W'(0) || words1 !== 16'd0 || bus1.fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_clear: valid=%b data=%h words=%0d rd_en=%b expected all zero",
               bus1.out_valid, bus1.out_data, words1, bus1.fifo_rd_en);
    end
    do_reset(1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    hold1 = 1'b0; hold2 = 1'b0;
    bus1.fifo_rst_busy = 1'b0; bus2.fifo_rst_busy = 1'b0;
    bus1.out_ready = 1'b0; bus2.out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_rst_busy();
    test_wrap();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
